clock_monitor: RTL and testbench

Fast-domain monitor for the divided slow clock used to pace the CPU. It synchronizes an incoming slow clock, produces one-cycle `tick` pulses on its rising edges, and measures its period and high time in `clk` cycles. It flags loss of the slow clock and reports lock when consecutive periods match. It sits beside the CPU core as the consumer of the slow clock, replacing direct use of the slow clock as a clock net.

---
 rtl/clock_monitor.sv | 147 ++++++++++++++
 tb/tb_clock_monitor.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/clock_monitor.sv
// rtl/clock_monitor.sv - slow-clock monitor: edge ticks, period/high-time measurement, lock and loss detect
`timescale 1ns/1ps
module clock_monitor #(
  parameter int          SYNC_STAGES = 2,
  parameter int          WIDTH       = 32,
  parameter int unsigned TIMEOUT     = 32'd100_000_000
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             clock_in,
  output logic             tick,
  output logic [WIDTH-1:0] period,
  output logic [WIDTH-1:0] high_time,
  output logic             period_valid,
  output logic             locked,
  output logic             lost
);

  localparam logic [WIDTH-1:0] TIMEOUT_W = WIDTH'(TIMEOUT);
  localparam logic [WIDTH-1:0] CNT_ONE   = WIDTH'(1);

  typedef enum logic [1:0] {ST_IDLE, ST_MEASURE, ST_LOST} state_t;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   s_d_q;
  logic                   s, rise, fall;
  logic [WIDTH-1:0]       cnt_q, cnt_d, hcnt_q;

  state_t                 state_q, state_d;
  logic [WIDTH-1:0]       period_q, period_d;
  logic [WIDTH-1:0]       high_q, high_d;
  logic                   pv_q, pv_d;
  logic                   locked_q, locked_d;
  logic                   lost_q, lost_d;
  // Set once a period has been reported since the last IDLE/LOST exit, so a
  // stale period that happens to match never produces lock on the first report.
  logic                   seen_q, seen_d;

  assign s    = sync_q[SYNC_STAGES-1];
  assign rise = s & ~s_d_q;
  assign fall = ~s & s_d_q;

  // Synchronizer chain plus one history flop for edge detection.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      sync_q <= '0;
      s_d_q  <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], clock_in};
      s_d_q  <= s;
    end
  end

  // Interval counter restarts on each rise and saturates at all-ones.
  always_comb begin
    cnt_d = cnt_q;
    if (rise) begin
      cnt_d = CNT_ONE;
    end else if (cnt_q != '1) begin
      cnt_d = cnt_q + CNT_ONE;
    end
  end

  // Counter register and high-phase capture on the falling edge.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cnt_q  <= '0;
      hcnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      if (fall) begin
        hcnt_q <= cnt_q;
      end
    end
  end

  // Measurement FSM: next state and registered result updates.
  always_comb begin
    state_d  = state_q;
    period_d = period_q;
    high_d   = high_q;
    pv_d     = 1'b0;
    locked_d = locked_q;
    lost_d   = lost_q;
    seen_d   = seen_q;
    unique case (state_q)
      ST_IDLE: begin
        if (rise) begin
          state_d = ST_MEASURE;
          seen_d  = 1'b0;
        end
      end
      ST_MEASURE: begin
        if (rise) begin
          period_d = cnt_q;
          high_d   = hcnt_q;
          pv_d     = 1'b1;
          locked_d = seen_q && (cnt_q == period_q);
          seen_d   = 1'b1;
        end else if (cnt_q == TIMEOUT_W) begin
          state_d  = ST_LOST;
          lost_d   = 1'b1;
          locked_d = 1'b0;
          seen_d   = 1'b0;
        end
      end
      ST_LOST: begin
        if (rise) begin
          state_d = ST_MEASURE;
          lost_d  = 1'b0;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // FSM state and output registers.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q  <= ST_IDLE;
      period_q <= '0;
      high_q   <= '0;
      pv_q     <= 1'b0;
      locked_q <= 1'b0;
      lost_q   <= 1'b0;
      seen_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      period_q <= period_d;
      high_q   <= high_d;
      pv_q     <= pv_d;
      locked_q <= locked_d;
      lost_q   <= lost_d;
      seen_q   <= seen_d;
    end
  end

  assign tick         = rise;
  assign period       = period_q;
  assign high_time    = high_q;
  assign period_valid = pv_q;
  assign locked       = locked_q;
  assign lost         = lost_q;

endmodule

// File: tb/tb_clock_monitor.sv
// tb/tb_clock_monitor.sv - directed self-checking bench for clock_monitor
`timescale 1ns/1ps
module tb_clock_monitor;

  logic clk = 1'b0;
  logic resetn;
  logic clock_in;

  wire [2:0]  tick_w, pv_w, locked_w, lost_w;
  wire [31:0] period_a, period_b, period_c;
  wire [31:0] high_a, high_b, high_c;

  int checks   = 0;
  int failures = 0;

  int hi_len = 3;
  int lo_len = 5;
  bit gen_en = 1'b0;

  always #5 clk = ~clk;

  clock_monitor #(.SYNC_STAGES(2), .WIDTH(32), .TIMEOUT(100)) u_a (
    .clk(clk), .resetn(resetn), .clock_in(clock_in), .tick(tick_w[0]),
    .period(period_a), .high_time(high_a), .period_valid(pv_w[0]),
    .locked(locked_w[0]), .lost(lost_w[0]));

  clock_monitor #(.SYNC_STAGES(2), .WIDTH(32), .TIMEOUT(20)) u_b (
    .clk(clk), .resetn(resetn), .clock_in(clock_in), .tick(tick_w[1]),
    .period(period_b), .high_time(high_b), .period_valid(pv_w[1]),
    .locked(locked_w[1]), .lost(lost_w[1]));

  clock_monitor #(.SYNC_STAGES(2), .WIDTH(32), .TIMEOUT(16)) u_c (
    .clk(clk), .resetn(resetn), .clock_in(clock_in), .tick(tick_w[2]),
    .period(period_c), .high_time(high_c), .period_valid(pv_w[2]),
    .locked(locked_w[2]), .lost(lost_w[2]));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Returns on the falling clk edge inside the rise cycle of instance idx.
  task automatic wait_tick(input int idx, input int budget, input string tag);
    bit ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (tick_w[idx]) begin
        ok = 1'b1;
        break;
      end
    end
    check({tag, "_seen"}, {31'd0, ok}, 32'd1);
  endtask

  // Slow clock generator: whole high/low phases, lengths read at phase start.
  initial begin
    clock_in = 1'b0;
    forever begin
      if (gen_en) begin
        clock_in = 1'b1;
        repeat (hi_len) @(negedge clk);
        clock_in = 1'b0;
        repeat (lo_len) @(negedge clk);
      end else begin
        clock_in = 1'b0;
        @(negedge clk);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int cnt_hits;
    bit got;

    // Reset held while the input toggles.
    resetn = 1'b0;
    gen_en = 1'b1;
    hi_len = 3;
    lo_len = 5;
    repeat (20) @(negedge clk);
    check("rst_tick",   {31'd0, tick_w[0]},   32'd0);
    check("rst_period", period_a,             32'd0);
    check("rst_high",   high_a,               32'd0);
    check("rst_pv",     {31'd0, pv_w[0]},     32'd0);
    check("rst_locked", {31'd0, locked_w[0]}, 32'd0);
    check("rst_lost",   {31'd0, lost_w[0]},   32'd0);

    // Release with the input parked low, then run 3 high / 5 low.
    gen_en = 1'b0;
    repeat (12) @(negedge clk);
    resetn = 1'b1;
    repeat (3) @(negedge clk);
    gen_en = 1'b1;
    wait_tick(0, 50, "first");
    @(negedge clk);
    check("first_no_pv", {31'd0, pv_w[0]},   32'd0);
    check("first_lost",  {31'd0, lost_w[0]}, 32'd0);
    wait_tick(0, 50, "second");
    @(negedge clk);
    check("p2_pv",     {31'd0, pv_w[0]},     32'd1);
    check("p2_period", period_a,             32'd8);
    check("p2_high",   high_a,               32'd3);
    check("p2_locked", {31'd0, locked_w[0]}, 32'd0);
    wait_tick(0, 50, "third");
    @(negedge clk);
    check("p3_pv",     {31'd0, pv_w[0]},     32'd1);
    check("p3_period", period_a,             32'd8);
    check("p3_locked", {31'd0, locked_w[0]}, 32'd1);
    @(negedge clk);
    check("p3_pv_one_cycle", {31'd0, pv_w[0]}, 32'd0);

    // Asynchronous reset between clk edges mid-period.
    wait_tick(0, 50, "ar");
    repeat (3) @(negedge clk);
    check("ar_pre_locked", {31'd0, locked_w[0]}, 32'd1);
    #2 resetn = 1'b0;
    #1;
    check("ar_period", period_a,             32'd0);
    check("ar_high",   high_a,               32'd0);
    check("ar_locked", {31'd0, locked_w[0]}, 32'd0);
    repeat (4) @(negedge clk);
    resetn = 1'b1;
    wait_tick(0, 50, "ar_first");
    @(negedge clk);
    check("ar_first_no_pv", {31'd0, pv_w[0]}, 32'd0);
    wait_tick(0, 50, "ar_second");
    @(negedge clk);
    check("ar_second_pv", {31'd0, pv_w[0]}, 32'd1);

    // Period change 8 -> 10 while locked.
    wait_tick(0, 50, "pc_settle");
    wait_tick(0, 50, "pc_pre");
    lo_len = 7;
    @(negedge clk);
    check("pc_pre_period", period_a,             32'd8);
    check("pc_pre_locked", {31'd0, locked_w[0]}, 32'd1);
    wait_tick(0, 50, "pc1");
    @(negedge clk);
    check("pc1_pv",     {31'd0, pv_w[0]},     32'd1);
    check("pc1_period", period_a,             32'd10);
    check("pc1_locked", {31'd0, locked_w[0]}, 32'd0);
    wait_tick(0, 50, "pc2");
    @(negedge clk);
    check("pc2_period", period_a,             32'd10);
    check("pc2_locked", {31'd0, locked_w[0]}, 32'd1);

    // Timeout on the TIMEOUT=20 instance.
    wait_tick(1, 50, "to_arm");
    check("to_pre_locked", {31'd0, locked_w[1]}, 32'd1);
    gen_en = 1'b0;
    n = 0;
    got = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      n++;
      if (lost_w[1]) begin
        got = 1'b1;
        break;
      end
    end
    check("to_lost",    {31'd0, got},         32'd1);
    check("to_latency", n,                    32'd21);
    check("to_locked",  {31'd0, locked_w[1]}, 32'd0);
    repeat (5) @(negedge clk);
    check("to_hold", {31'd0, lost_w[1]}, 32'd1);
    gen_en = 1'b1;
    wait_tick(1, 50, "re1");
    check("re1_lost_at_tick", {31'd0, lost_w[1]}, 32'd1);
    @(negedge clk);
    check("re1_lost_cleared", {31'd0, lost_w[1]}, 32'd0);
    check("re1_no_pv",        {31'd0, pv_w[1]},   32'd0);
    wait_tick(1, 50, "re2");
    @(negedge clk);
    check("re2_pv",     {31'd0, pv_w[1]},     32'd1);
    check("re2_period", period_b,             32'd10);
    check("re2_high",   high_b,               32'd3);
    check("re2_locked", {31'd0, locked_w[1]}, 32'd0);
    wait_tick(1, 50, "re3");
    @(negedge clk);
    check("re3_locked", {31'd0, locked_w[1]}, 32'd1);

    // Divider-style input, 26 high / 26 low.
    wait_tick(0, 50, "div_arm");
    hi_len = 26;
    lo_len = 26;
    wait_tick(0, 200, "div1");
    wait_tick(0, 200, "div2");
    wait_tick(0, 200, "div3");
    wait_tick(0, 200, "div4");
    @(negedge clk);
    check("div_pv",         {31'd0, pv_w[0]},     32'd1);
    check("div_period",     period_a,             32'd52);
    check("div_high",       high_a,               32'd26);
    check("div_locked",     {31'd0, locked_w[0]}, 32'd1);
    check("div_tick_width", {31'd0, tick_w[0]},   32'd0);
    cnt_hits = 0;
    for (int i = 0; i < 52; i++) begin
      @(negedge clk);
      if (tick_w[0]) cnt_hits++;
    end
    check("div_ticks_per_period", cnt_hits, 32'd1);

    // Rising edge exactly at cnt == TIMEOUT on the TIMEOUT=16 instance.
    wait_tick(2, 200, "bd_arm");
    hi_len = 8;
    lo_len = 8;
    wait_tick(2, 200, "bd1");
    wait_tick(2, 200, "bd2");
    wait_tick(2, 200, "bd3");
    wait_tick(2, 200, "bd4");
    wait_tick(2, 200, "bd5");
    @(negedge clk);
    check("bd_pv",     {31'd0, pv_w[2]},     32'd1);
    check("bd_period", period_c,             32'd16);
    check("bd_high",   high_c,               32'd8);
    check("bd_lost",   {31'd0, lost_w[2]},   32'd0);
    check("bd_locked", {31'd0, locked_w[2]}, 32'd1);
    cnt_hits = 0;
    for (int i = 0; i < 48; i++) begin
      @(negedge clk);
      if (lost_w[2]) cnt_hits++;
    end
    check("bd_lost_window", cnt_hits, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
